// File: rtl/poly_eval_arbiter_if.sv
// Request, response and datapath-control bundle for poly_eval_arbiter.
// The slave modport is the arbiter's view; master is the requester/consumer/datapath side.
interface poly_eval_arbiter_if;
  logic        req0_valid;
  logic        req1_valid;
  logic [31:0] req0_data;
  logic [31:0] req1_data;
  logic        req0_ready;
  logic        req1_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_data;
  logic        rsp_id;
  logic        busy;
  logic [7:0]  dp_data_in;
  logic        dp_ld_a;
  logic        dp_ld_b;
  logic        dp_ld_c;
  logic        dp_ld_x;
  logic        dp_ld_r;
  logic        dp_ld_alu_out;
  logic [1:0]  dp_alu_select_a;
  logic [1:0]  dp_alu_select_b;
  logic        dp_alu_op;
  logic [7:0]  dp_result;

  modport slave (
    input  req0_valid, req1_valid, req0_data, req1_data, rsp_ready, dp_result,
    output req0_ready, req1_ready, rsp_valid, rsp_data, rsp_id, busy,
           dp_data_in, dp_ld_a, dp_ld_b, dp_ld_c, dp_ld_x, dp_ld_r, dp_ld_alu_out,
           dp_alu_select_a, dp_alu_select_b, dp_alu_op
  );

  modport master (
    output req0_valid, req1_valid, req0_data, req1_data, rsp_ready, dp_result,
    input  req0_ready, req1_ready, rsp_valid, rsp_data, rsp_id, busy,
           dp_data_in, dp_ld_a, dp_ld_b, dp_ld_c, dp_ld_x, dp_ld_r, dp_ld_alu_out,
           dp_alu_select_a, dp_alu_select_b, dp_alu_op
  );
endinterface

// File: rtl/poly_eval_arbiter.sv
// Two-port arbiter + sequencer computing r = a*x^2 + b*x + c on a shared 8-bit datapath.
// Define POLY_EVAL_ARB_RR_EN for round-robin tie-breaking; default is fixed priority (req0 wins).
//
// state | meaning
// IDLE  | arbitrate, accept one job
// LD_A..LD_X | load job bytes into datapath
// C0,C1 | a <= a*x
// C2    | b <= b*x
// C3    | b <= b+c
// C4    | r <= a+b
// RESP  | present result until rsp_ready
module poly_eval_arbiter (
  input logic                clk,
  input logic                reset,
  poly_eval_arbiter_if.slave bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_LD_A, S_LD_B, S_LD_C, S_LD_X, S_C0, S_C1, S_C2, S_C3, S_C4, S_RESP
  } state_t;

  typedef struct packed {
    logic [7:0] data_in;
    logic       ld_a;
    logic       ld_b;
    logic       ld_c;
    logic       ld_x;
    logic       ld_r;
    logic       ld_alu_out;
    logic [1:0] sel_a;
    logic [1:0] sel_b;
    logic       op;
  } ctrl_t;

  state_t      state_q, state_d;
  logic [31:0] job_q, job_d;
  logic        grant_q, grant_d;
  ctrl_t       ctrl_q, ctrl_d;
  logic        rsp_valid_q, rsp_id_q, busy_q;
  logic        pick1, hs;

`ifdef POLY_EVAL_ARB_RR_EN
  logic last_grant_q;
  assign pick1 = bus.req1_valid & (~bus.req0_valid | ~last_grant_q);
`else
  assign pick1 = bus.req1_valid & ~bus.req0_valid;
`endif

  assign bus.req0_ready = (state_q == S_IDLE) & bus.req0_valid & ~pick1;
  assign bus.req1_ready = (state_q == S_IDLE) & pick1;
  assign hs             = bus.req0_ready | bus.req1_ready;
  assign bus.rsp_data   = bus.dp_result;

  always_comb begin
    state_d = state_q;
    job_d   = job_q;
    grant_d = grant_q;
    case (state_q)
      S_IDLE: if (hs) begin
        state_d = S_LD_A;
        job_d   = pick1 ? bus.req1_data : bus.req0_data;
        grant_d = pick1;
      end
      S_LD_A: state_d = S_LD_B;
      S_LD_B: state_d = S_LD_C;
      S_LD_C: state_d = S_LD_X;
      S_LD_X: state_d = S_C0;
      S_C0:   state_d = S_C1;
      S_C1:   state_d = S_C2;
      S_C2:   state_d = S_C3;
      S_C3:   state_d = S_C4;
      S_C4:   state_d = S_RESP;
      S_RESP: if (bus.rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Strobes are decoded from the next state so they come out of flops aligned with it.
  always_comb begin
    ctrl_d = '0;
    case (state_d)
      S_LD_A: begin ctrl_d.data_in = job_d[31:24]; ctrl_d.ld_a = 1'b1; end
      S_LD_B: begin ctrl_d.data_in = job_d[23:16]; ctrl_d.ld_b = 1'b1; end
      S_LD_C: begin ctrl_d.data_in = job_d[15:8];  ctrl_d.ld_c = 1'b1; end
      S_LD_X: begin ctrl_d.data_in = job_d[7:0];   ctrl_d.ld_x = 1'b1; end
      S_C0, S_C1: begin
        ctrl_d.ld_a = 1'b1; ctrl_d.ld_alu_out = 1'b1;
        ctrl_d.sel_a = 2'd0; ctrl_d.sel_b = 2'd3; ctrl_d.op = 1'b1;
      end
      S_C2: begin
        ctrl_d.ld_b = 1'b1; ctrl_d.ld_alu_out = 1'b1;
        ctrl_d.sel_a = 2'd1; ctrl_d.sel_b = 2'd3; ctrl_d.op = 1'b1;
      end
      S_C3: begin
        ctrl_d.ld_b = 1'b1; ctrl_d.ld_alu_out = 1'b1;
        ctrl_d.sel_a = 2'd1; ctrl_d.sel_b = 2'd2; ctrl_d.op = 1'b0;
      end
      S_C4: begin
        ctrl_d.ld_r = 1'b1; ctrl_d.sel_a = 2'd0; ctrl_d.sel_b = 2'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      job_q       <= '0;
      grant_q     <= 1'b0;
      ctrl_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      busy_q      <= 1'b0;
`ifdef POLY_EVAL_ARB_RR_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      job_q       <= job_d;
      grant_q     <= grant_d;
      ctrl_q      <= ctrl_d;
      rsp_valid_q <= (state_d == S_RESP);
      rsp_id_q    <= (state_d == S_RESP) ? grant_d : 1'b0;
      busy_q      <= (state_d != S_IDLE);
`ifdef POLY_EVAL_ARB_RR_EN
      if (hs) last_grant_q <= pick1;
`endif
    end
  end

  assign bus.rsp_valid       = rsp_valid_q;
  assign bus.rsp_id          = rsp_id_q;
  assign bus.busy            = busy_q;
  assign bus.dp_data_in      = ctrl_q.data_in;
  assign bus.dp_ld_a         = ctrl_q.ld_a;
  assign bus.dp_ld_b         = ctrl_q.ld_b;
  assign bus.dp_ld_c         = ctrl_q.ld_c;
  assign bus.dp_ld_x         = ctrl_q.ld_x;
  assign bus.dp_ld_r         = ctrl_q.ld_r;
  assign bus.dp_ld_alu_out   = ctrl_q.ld_alu_out;
  assign bus.dp_alu_select_a = ctrl_q.sel_a;
  assign bus.dp_alu_select_b = ctrl_q.sel_b;
  assign bus.dp_alu_op       = ctrl_q.op;

endmodule

// File: tb/tb_poly_eval_arbiter.sv
// Directed bench for poly_eval_arbiter with a behavioural model of the shared datapath.
module tb_poly_eval_arbiter;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  poly_eval_arbiter_if bus();
  poly_eval_arbiter dut (.clk(clk), .reset(reset), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;

  // datapath model: registers a,b,c,x,r and one ALU
  logic [7:0] ra, rb, rc, rx, rr, opa, opb, alu;
  always_comb begin
    case (bus.dp_alu_select_a)
      2'd0: opa = ra; 2'd1: opa = rb; 2'd2: opa = rc; default: opa = rx;
    endcase
    case (bus.dp_alu_select_b)
      2'd0: opb = ra; 2'd1: opb = rb; 2'd2: opb = rc; default: opb = rx;
    endcase
    alu = bus.dp_alu_op ? opa * opb : opa + opb;
  end
  always @(posedge clk) begin
    if (reset) begin
      ra <= 8'd0; rb <= 8'd0; rc <= 8'd0; rx <= 8'd0; rr <= 8'd0;
    end else begin
      if (bus.dp_ld_a) ra <= bus.dp_ld_alu_out ? alu : bus.dp_data_in;
      if (bus.dp_ld_b) rb <= bus.dp_ld_alu_out ? alu : bus.dp_data_in;
      if (bus.dp_ld_c) rc <= bus.dp_ld_alu_out ? alu : bus.dp_data_in;
      if (bus.dp_ld_x) rx <= bus.dp_ld_alu_out ? alu : bus.dp_data_in;
      if (bus.dp_ld_r) rr <= alu;
    end
  end
  assign bus.dp_result = rr;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    reset = 1'b1; tick(); tick(); reset = 1'b0;
  endtask

  // Offers one job, returns acceptance, latency to rsp_valid, data and id; ends back in IDLE.
  task automatic run_job(input bit id, input logic [31:0] job, output bit acc,
                         output int lat, output logic [7:0] data, output logic rid);
    acc = 1'b0; lat = -1; data = 8'hxx; rid = 1'bx;
    bus.rsp_ready = 1'b1;
    if (id) begin bus.req1_valid = 1'b1; bus.req1_data = job; end
    else    begin bus.req0_valid = 1'b1; bus.req0_data = job; end
    #1;
    acc = id ? bus.req1_ready : bus.req0_ready;
    tick();
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    bus.req0_data = 32'hFFFF_FFFF; bus.req1_data = 32'hFFFF_FFFF;
    for (int c = 1; c <= 30; c++) begin
      if (bus.rsp_valid) begin
        lat = c; data = bus.rsp_data; rid = bus.rsp_id;
        break;
      end
      tick();
    end
    tick();
  endtask

  task automatic test_reset();
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0; bus.rsp_ready = 1'b0;
    bus.req0_data = '0; bus.req1_data = '0;
    reset = 1'b1; tick(); tick();
    n_checks++;
    if ({bus.rsp_valid, bus.rsp_id, bus.busy, bus.req0_ready, bus.req1_ready} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctl: got %b expected 00000",
               {bus.rsp_valid, bus.rsp_id, bus.busy, bus.req0_ready, bus.req1_ready});
    end
    n_checks++;
    if ({bus.dp_data_in, bus.dp_ld_a, bus.dp_ld_b, bus.dp_ld_c, bus.dp_ld_x, bus.dp_ld_r,
         bus.dp_ld_alu_out, bus.dp_alu_select_a, bus.dp_alu_select_b, bus.dp_alu_op} !== 19'b0) begin
      n_fail++;
      $display("FAIL reset_dp: got %h expected 0",
               {bus.dp_data_in, bus.dp_ld_a, bus.dp_ld_b, bus.dp_ld_c, bus.dp_ld_x, bus.dp_ld_r,
                bus.dp_ld_alu_out, bus.dp_alu_select_a, bus.dp_alu_select_b, bus.dp_alu_op});
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    bit acc; int lat; logic [7:0] d; logic rid;
    do_reset();
    run_job(1'b0, {8'd2, 8'd3, 8'd4, 8'd5}, acc, lat, d, rid);
    n_checks++; if (acc !== 1'b1) begin n_fail++; $display("FAIL basic_ready: got %b expected 1", acc); end
    n_checks++; if (lat != 10) begin n_fail++; $display("FAIL basic_latency: got %0d expected 10", lat); end
    n_checks++; if (d !== 8'h45) begin n_fail++; $display("FAIL basic_data: got %h expected 45", d); end
    n_checks++; if (rid !== 1'b0) begin n_fail++; $display("FAIL basic_id: got %b expected 0", rid); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL basic_idle: busy %b expected 0", bus.busy); end
  endtask

  task automatic test_wrap();
    bit acc; int lat; logic [7:0] d; logic rid;
    run_job(1'b1, {8'd16, 8'd0, 8'd1, 8'd4}, acc, lat, d, rid);
    n_checks++; if (acc !== 1'b1) begin n_fail++; $display("FAIL wrap_ready: got %b expected 1", acc); end
    n_checks++; if (lat != 10) begin n_fail++; $display("FAIL wrap_latency: got %0d expected 10", lat); end
    n_checks++; if (d !== 8'h01) begin n_fail++; $display("FAIL wrap_data: got %h expected 01", d); end
    n_checks++; if (rid !== 1'b1) begin n_fail++; $display("FAIL wrap_id: got %b expected 1", rid); end
  endtask

  task automatic test_tie();
    int hs_id [4]; int hs_cyc [4]; int n_hs = 0;
    int rs_id [4]; int rs_dat [4]; int rs_cyc [4]; int n_rs = 0;
    int cnt0 = 2; int cnt1 = 1;
    int e_hs_id [3]; int e_rs_id [3]; int e_rs_dat [3];
    do_reset();
    bus.rsp_ready = 1'b1;
    bus.req0_data = {8'd1, 8'd0, 8'd0, 8'd2};
    bus.req1_data = {8'd0, 8'd1, 8'd7, 8'd3};
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (bus.req0_valid && bus.req0_ready && n_hs < 4) begin
        hs_id[n_hs] = 0; hs_cyc[n_hs] = c; n_hs++; cnt0--;
      end
      if (bus.req1_valid && bus.req1_ready && n_hs < 4) begin
        hs_id[n_hs] = 1; hs_cyc[n_hs] = c; n_hs++; cnt1--;
      end
      if (bus.rsp_valid && n_rs < 4) begin
        rs_id[n_rs] = int'(bus.rsp_id); rs_dat[n_rs] = int'(bus.rsp_data); rs_cyc[n_rs] = c; n_rs++;
      end
      tick();
      if (cnt0 <= 0) bus.req0_valid = 1'b0;
      if (cnt1 <= 0) bus.req1_valid = 1'b0;
    end
`ifdef POLY_EVAL_ARB_RR_EN
    e_hs_id = '{0, 1, 0}; e_rs_id = '{0, 1, 0}; e_rs_dat = '{4, 10, 4};
`else
    e_hs_id = '{0, 0, 1}; e_rs_id = '{0, 0, 1}; e_rs_dat = '{4, 4, 10};
`endif
    n_checks++;
    if (n_hs != 3 || n_rs != 3) begin
      n_fail++; $display("FAIL tie_counts: handshakes %0d responses %0d expected 3 and 3", n_hs, n_rs);
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (hs_id[i] != e_hs_id[i] || hs_cyc[i] != 11 * i) begin
          n_fail++;
          $display("FAIL tie_grant%0d: id %0d at cycle %0d expected id %0d at cycle %0d",
                   i, hs_id[i], hs_cyc[i], e_hs_id[i], 11 * i);
        end
        n_checks++;
        if (rs_id[i] != e_rs_id[i] || rs_dat[i] != e_rs_dat[i] || rs_cyc[i] != 11 * i + 10) begin
          n_fail++;
          $display("FAIL tie_rsp%0d: id %0d data %0d cycle %0d expected id %0d data %0d cycle %0d",
                   i, rs_id[i], rs_dat[i], rs_cyc[i], e_rs_id[i], e_rs_dat[i], 11 * i + 10);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.rsp_ready = 1'b0;
    bus.req0_data = {8'd2, 8'd3, 8'd4, 8'd5};
    bus.req0_valid = 1'b1;
    tick();
    bus.req0_valid = 1'b0;
    bus.req0_data = 32'h0;
    for (int c = 2; c <= 10; c++) tick();
    for (int i = 0; i < 5; i++) begin
      bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
      #1;
      n_checks++;
      if ({bus.rsp_valid, bus.busy, bus.req0_ready, bus.req1_ready} !== 4'b1100 || bus.rsp_data !== 8'h45) begin
        n_fail++;
        $display("FAIL bp_hold%0d: valid/busy/rdy0/rdy1 %b data %h expected 1100 data 45", i,
                 {bus.rsp_valid, bus.busy, bus.req0_ready, bus.req1_ready}, bus.rsp_data);
      end
      if (i == 4) bus.rsp_ready = 1'b1;
      tick();
    end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    n_checks++;
    if ({bus.rsp_valid, bus.busy} !== 2'b00) begin
      n_fail++; $display("FAIL bp_release: valid/busy %b expected 00", {bus.rsp_valid, bus.busy});
    end
  endtask

  task automatic test_reset_mid();
    bit acc; int lat; logic [7:0] d; logic rid;
    do_reset();
    bus.rsp_ready = 1'b1;
    bus.req0_data = {8'd9, 8'd9, 8'd9, 8'd9};
    bus.req0_valid = 1'b1;
    tick();
    bus.req0_valid = 1'b0;
    for (int c = 2; c <= 7; c++) tick();
    n_checks++;
    if ({bus.dp_ld_b, bus.dp_alu_op, bus.dp_alu_select_a, bus.dp_alu_select_b} !== 6'b11_0111) begin
      n_fail++; $display("FAIL mid_c2: got %b expected 110111",
                         {bus.dp_ld_b, bus.dp_alu_op, bus.dp_alu_select_a, bus.dp_alu_select_b});
    end
    reset = 1'b1;
    tick();
    n_checks++;
    if ({bus.rsp_valid, bus.rsp_id, bus.busy, bus.dp_data_in, bus.dp_ld_a, bus.dp_ld_b, bus.dp_ld_c,
         bus.dp_ld_x, bus.dp_ld_r, bus.dp_ld_alu_out, bus.dp_alu_select_a, bus.dp_alu_select_b,
         bus.dp_alu_op} !== 22'b0) begin
      n_fail++; $display("FAIL mid_reset: outputs not all zero, busy %b rsp_valid %b", bus.busy, bus.rsp_valid);
    end
    reset = 1'b0;
    run_job(1'b0, {8'd2, 8'd3, 8'd4, 8'd5}, acc, lat, d, rid);
    n_checks++;
    if (acc !== 1'b1 || lat != 10 || d !== 8'h45) begin
      n_fail++; $display("FAIL mid_rerun: acc %b lat %0d data %h expected 1 10 45", acc, lat, d);
    end
  endtask

  task automatic test_strobes();
    logic [18:0] exp_v [1:10];
    logic [18:0] got;
    exp_v[1]  = {8'd2, 6'b100000, 2'd0, 2'd0, 1'b0};
    exp_v[2]  = {8'd3, 6'b010000, 2'd0, 2'd0, 1'b0};
    exp_v[3]  = {8'd4, 6'b001000, 2'd0, 2'd0, 1'b0};
    exp_v[4]  = {8'd5, 6'b000100, 2'd0, 2'd0, 1'b0};
    exp_v[5]  = {8'd0, 6'b100001, 2'd0, 2'd3, 1'b1};
    exp_v[6]  = {8'd0, 6'b100001, 2'd0, 2'd3, 1'b1};
    exp_v[7]  = {8'd0, 6'b010001, 2'd1, 2'd3, 1'b1};
    exp_v[8]  = {8'd0, 6'b010001, 2'd1, 2'd2, 1'b0};
    exp_v[9]  = {8'd0, 6'b000010, 2'd0, 2'd1, 1'b0};
    exp_v[10] = 19'b0;
    do_reset();
    bus.rsp_ready = 1'b1;
    bus.req0_data = {8'd2, 8'd3, 8'd4, 8'd5};
    bus.req0_valid = 1'b1;
    tick();
    bus.req0_valid = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      got = {bus.dp_data_in, bus.dp_ld_a, bus.dp_ld_b, bus.dp_ld_c, bus.dp_ld_x, bus.dp_ld_r,
             bus.dp_ld_alu_out, bus.dp_alu_select_a, bus.dp_alu_select_b, bus.dp_alu_op};
      n_checks++;
      if (got !== exp_v[c]) begin
        n_fail++; $display("FAIL strobe_c%0d: got %h expected %h", c, got, exp_v[c]);
      end
      n_checks++;
      if ($countones({bus.dp_ld_a, bus.dp_ld_b, bus.dp_ld_c, bus.dp_ld_x, bus.dp_ld_r}) != ((c <= 9) ? 1 : 0)) begin
        n_fail++; $display("FAIL onehot_c%0d: loads %b", c,
                           {bus.dp_ld_a, bus.dp_ld_b, bus.dp_ld_c, bus.dp_ld_x, bus.dp_ld_r});
      end
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    test_reset();
    test_basic();
    test_wrap();
    test_tie();
    test_backpressure();
    test_reset_mid();
    test_strobes();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
